// File: rtl/shaper_cfg_ctrl.sv
// shaper_cfg_ctrl
// ---------------
// Runtime configuration and sequencing controller for the trapezoidal
// shaping filter. Slow-control writes land in a shadow register set. An
// apply strobe checks the shadow set and, if it is legal, copies it to the
// active set that drives the filter. The controller then holds the filter
// in reset (FLUSH) and masks out_valid until the filter pipeline has
// settled (SETTLE). After that it reports trustworthy data (RUN).
//
// Optional feature: define SHAPER_CFG_READBACK_EN to add cfg_rd/cfg_rdata.
// cfg_rdata returns the active coefficient selected by cfg_addr.
//
// Ports:
//   clk          clock
//   reset        synchronous, active-low reset
//   cfg_wr       one-cycle write strobe (shadow[cfg_addr] <= cfg_wdata)
//   cfg_addr     0=k, 1=l, 2=m1, 3=m2
//   cfg_wdata    write data
//   cfg_apply    one-cycle strobe: commit shadow set to active set
//   cfg_rd       (readback only) read strobe for the active set
//   cfg_rdata    (readback only) read data, valid the cycle after cfg_rd
//   cfg_ack      pulse one cycle after cfg_wr (or cfg_rd)
//   cfg_err      pulse one cycle after a rejected apply
//   busy         high while in FLUSH or SETTLE
//   filt_rst_n   active-low reset to the filter
//   k_act..m2_act active coefficients to the filter
//   out_valid    filter output trustworthy (RUN)

module shaper_cfg_ctrl #(
    parameter int CFG_W     = 16,
    parameter int K_DEF     = 16,
    parameter int L_DEF     = 8,
    parameter int M1_DEF    = 2,
    parameter int M2_DEF    = 3,
    parameter int K_MAX     = 64,
    parameter int FLUSH_CYC = 4,
    parameter int PIPE_LAT  = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_wr,
    input  logic [1:0]       cfg_addr,
    input  logic [CFG_W-1:0] cfg_wdata,
    input  logic             cfg_apply,
`ifdef SHAPER_CFG_READBACK_EN
    input  logic             cfg_rd,
    output logic [CFG_W-1:0] cfg_rdata,
`endif
    output logic             cfg_ack,
    output logic             cfg_err,
    output logic             busy,
    output logic             filt_rst_n,
    output logic [CFG_W-1:0] k_act,
    output logic [CFG_W-1:0] l_act,
    output logic [CFG_W-1:0] m1_act,
    output logic [CFG_W-1:0] m2_act,
    output logic             out_valid
);

    // Two extra bits so k+l+PIPE_LAT can never wrap the settle counter.
    localparam int CNT_W = CFG_W + 2;

    localparam logic [CFG_W-1:0] K_MAX_C    = CFG_W'(K_MAX);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYC - 1);

    // Index 0 is k, 1 is l, 2 is m1, 3 is m2 (matches cfg_addr).
    localparam logic [3:0][CFG_W-1:0] DEF_SET = {
        CFG_W'(M2_DEF), CFG_W'(M1_DEF), CFG_W'(L_DEF), CFG_W'(K_DEF)
    };

    typedef enum logic [1:0] {
        ST_FLUSH,
        ST_SETTLE,
        ST_RUN
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [3:0][CFG_W-1:0]   shadow_q, shadow_d;
    logic [3:0][CFG_W-1:0]   act_q, act_d;
    logic                    ack_q, ack_d;
    logic                    err_q, err_d;
    logic                    filt_rst_n_q, filt_rst_n_d;
    logic                    out_valid_q, out_valid_d;
    logic                    busy_q, busy_d;
    logic                    apply_ok;
    logic [CNT_W-1:0]        settle_last;

    // Shadow merge: a write in the same cycle as an apply is folded in first,
    // so the apply checks and commits the post-write shadow set.
    always_comb begin
        shadow_d = shadow_q;
        if (cfg_wr) begin
            shadow_d[cfg_addr] = cfg_wdata;
        end
    end

    // Legal set: 1 <= k <= K_MAX and l < k; m1/m2 are unrestricted.
    assign apply_ok = (shadow_d[0] != '0) && (shadow_d[0] <= K_MAX_C) &&
                      (shadow_d[1] < shadow_d[0]);

    // Last SETTLE count value, derived from the set the filter is running on.
    assign settle_last = {2'b00, act_q[0]} + {2'b00, act_q[1]} +
                         CNT_W'(PIPE_LAT) - CNT_W'(1);

    // Sequencer next state. An accepted apply overrides the normal
    // FLUSH -> SETTLE -> RUN progress from any state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        act_d   = act_q;
        err_d   = 1'b0;

        case (state_q)
            ST_FLUSH: begin
                if (cnt_q == FLUSH_LAST) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                if (cnt_q == settle_last) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_FLUSH;
                cnt_d   = '0;
            end
        endcase

        if (cfg_apply) begin
            if (apply_ok) begin
                act_d   = shadow_d;
                state_d = ST_FLUSH;
                cnt_d   = '0;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // Status outputs are registered from the next state so they line up
    // with the state they describe.
    always_comb begin
        ack_d        = cfg_wr;
        filt_rst_n_d = (state_d != ST_FLUSH);
        out_valid_d  = (state_d == ST_RUN);
        busy_d       = (state_d != ST_RUN);
`ifdef SHAPER_CFG_READBACK_EN
        ack_d        = cfg_wr | cfg_rd;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_FLUSH;
            cnt_q        <= '0;
            shadow_q     <= DEF_SET;
            act_q        <= DEF_SET;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            filt_rst_n_q <= 1'b0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shadow_q     <= shadow_d;
            act_q        <= act_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            filt_rst_n_q <= filt_rst_n_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
        end
    end

`ifdef SHAPER_CFG_READBACK_EN
    logic [CFG_W-1:0] rdata_q, rdata_d;

    // Readback samples the active set before this edge, so a coincident
    // write or apply does not affect the returned value.
    always_comb begin
        rdata_d = rdata_q;
        if (cfg_rd) begin
            rdata_d = act_q[cfg_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign cfg_rdata = rdata_q;
`endif

    assign cfg_ack    = ack_q;
    assign cfg_err    = err_q;
    assign busy       = busy_q;
    assign filt_rst_n = filt_rst_n_q;
    assign out_valid  = out_valid_q;
    assign k_act      = act_q[0];
    assign l_act      = act_q[1];
    assign m1_act     = act_q[2];
    assign m2_act     = act_q[3];

endmodule

// File: tb/tb_shaper_cfg_ctrl.sv
// Testbench for shaper_cfg_ctrl.
// The reference model tracks the shadow and active sets and the edge at which
// FLUSH was last entered. Every output is then derived from the elapsed cycle
// count: the filter is out of reset once FLUSH_CYC cycles have passed, and
// data is valid once k+l+PIPE_LAT more have passed. Expected outputs are
// queued per clock edge, and a monitor on the falling edge pops and compares.

module tb_shaper_cfg_ctrl;

    localparam int CFG_W     = 16;
    localparam int K_MAX     = 64;
    localparam int FLUSH_CYC = 4;
    localparam int PIPE_LAT  = 6;

    logic             clk = 1'b0;
    logic             reset;
    logic             cfg_wr;
    logic [1:0]       cfg_addr;
    logic [CFG_W-1:0] cfg_wdata;
    logic             cfg_apply;
    logic             cfg_rd;
    logic             cfg_ack;
    logic             cfg_err;
    logic             busy;
    logic             filt_rst_n;
    logic [CFG_W-1:0] k_act, l_act, m1_act, m2_act;
    logic             out_valid;
`ifdef SHAPER_CFG_READBACK_EN
    logic [CFG_W-1:0] cfg_rdata;
`endif

    always #5 clk = ~clk;

    shaper_cfg_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_wr     (cfg_wr),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_apply  (cfg_apply),
`ifdef SHAPER_CFG_READBACK_EN
        .cfg_rd     (cfg_rd),
        .cfg_rdata  (cfg_rdata),
`endif
        .cfg_ack    (cfg_ack),
        .cfg_err    (cfg_err),
        .busy       (busy),
        .filt_rst_n (filt_rst_n),
        .k_act      (k_act),
        .l_act      (l_act),
        .m1_act     (m1_act),
        .m2_act     (m2_act),
        .out_valid  (out_valid)
    );

    typedef struct {
        logic        ack;
        logic        err;
        logic [2:0]  status;   // {filt_rst_n, out_valid, busy}
        logic [63:0] coeffs;   // {k, l, m1, m2}
        logic [15:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_x;

    int total = 0;
    int bad   = 0;

    logic [15:0] sh [4];
    logic [15:0] ac [4];
    logic [15:0] rd_m;
    int          edge_n = 0;
    int          entry  = 0;

    // Compare one value and report mismatches.
    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Advance the reference model across one clock edge and queue the
    // outputs it predicts for the following cycle.
    task automatic modelStep(input logic rst, input logic wr,
                             input logic [1:0] addr, input logic [15:0] wdata,
                             input logic apl, input logic rd);
        exp_t x;
        int   e;
        int   settle;
        edge_n++;
        x.ack = 1'b0;
        x.err = 1'b0;
        if (!rst) begin
            sh[0] = 16; sh[1] = 8; sh[2] = 2; sh[3] = 3;
            ac = sh;
            entry = edge_n;
            rd_m = '0;
        end else begin
            if (rd) rd_m = ac[addr];
            if (wr) sh[addr] = wdata;
            x.ack = wr | rd;
            if (apl) begin
                if (sh[0] >= 1 && int'(sh[0]) <= K_MAX && sh[1] < sh[0]) begin
                    ac = sh;
                    entry = edge_n;
                end else begin
                    x.err = 1'b1;
                end
            end
        end
        e      = edge_n - entry;
        settle = int'(ac[0]) + int'(ac[1]) + PIPE_LAT;
        x.status[2] = (e >= FLUSH_CYC);
        x.status[1] = (e >= FLUSH_CYC + settle);
        x.status[0] = !(e >= FLUSH_CYC + settle);
        x.coeffs = {ac[0], ac[1], ac[2], ac[3]};
        x.rdata  = rd_m;
        exp_q.push_back(x);
    endtask

    // Drive one cycle of inputs, update the model, and step past the edge.
    task automatic applyStimulus(input logic rst, input logic wr,
                                 input logic [1:0] addr, input logic [15:0] wdata,
                                 input logic apl, input logic rd);
        reset     = rst;
        cfg_wr    = wr;
        cfg_addr  = addr;
        cfg_wdata = wdata;
        cfg_apply = apl;
        cfg_rd    = rd;
        modelStep(rst, wr, addr, wdata, apl, rd);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 2'd0, 16'd0, 1'b0, 1'b0);
    endtask

    // Idle until out_valid rises (bounded) and check the cycle count.
    task automatic waitValid(input string name, input int req);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 400) begin
            idle(1);
            n++;
        end
        checkOutput(name, 64'(n), 64'(req));
    endtask

    // Monitor: one queued expectation per clock edge, checked mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_x = exp_q.pop_front();
            checkOutput("ack_err", {62'd0, cfg_ack, cfg_err}, {62'd0, mon_x.ack, mon_x.err});
            checkOutput("status", {61'd0, filt_rst_n, out_valid, busy}, {61'd0, mon_x.status});
            checkOutput("coeffs", {k_act, l_act, m1_act, m2_act}, mon_x.coeffs);
`ifdef SHAPER_CFG_READBACK_EN
            checkOutput("rdata", {48'd0, cfg_rdata}, {48'd0, mon_x.rdata});
`endif
        end
    end

    initial begin
        logic        r_rst, r_wr, r_apl, r_rd;
        logic [1:0]  r_addr;
        logic [15:0] r_data;

        // Power-up reset, then count cycles to out_valid: 4 flush + 30 settle.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 1'b0);
        waitValid("rise_after_reset", 34);

        // Write k=32, l=10, apply: 4 flush + 48 settle.
        applyStimulus(1'b1, 1'b1, 2'd0, 16'd32, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 2'd1, 16'd10, 1'b0, 1'b0);
        idle(2);
        applyStimulus(1'b1, 1'b0, 2'd0, 16'd0, 1'b1, 1'b0);
        waitValid("rise_after_apply", 52);

        // l=40 with k=32 is rejected while staying in RUN.
        applyStimulus(1'b1, 1'b1, 2'd1, 16'd40, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'd0, 16'd0, 1'b1, 1'b0);
        idle(5);

        // Re-apply in the middle of SETTLE with k=20, l=4.
        applyStimulus(1'b1, 1'b1, 2'd1, 16'd10, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'd0, 16'd0, 1'b1, 1'b0);
        idle(FLUSH_CYC + 8);
        applyStimulus(1'b1, 1'b1, 2'd0, 16'd20, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 2'd1, 16'd4, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'd0, 16'd0, 1'b1, 1'b0);
        waitValid("rise_after_restart", 34);

        // Same-cycle write+apply: k=0 rejected, then k=12 with l=8 accepted.
        applyStimulus(1'b1, 1'b1, 2'd0, 16'd0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 2'd1, 16'd8, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 2'd0, 16'd12, 1'b1, 1'b0);
        idle(10);

        // Boundary k=K_MAX is legal, k=K_MAX+1 is not.
        applyStimulus(1'b1, 1'b1, 2'd0, 16'd65, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 2'd0, 16'd64, 1'b1, 1'b0);
        idle(FLUSH_CYC + 10);

        // Reset during SETTLE returns everything to defaults.
        applyStimulus(1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 1'b0);
        idle(5);

`ifdef SHAPER_CFG_READBACK_EN
        // Readback of each active coefficient, and read colliding with write.
        for (int a = 0; a < 4; a++) applyStimulus(1'b1, 1'b0, 2'(a), 16'd0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 2'd2, 16'h1234, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 2'd0, 16'd0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 2'd2, 16'd0, 1'b0, 1'b1);
`endif

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            r_rst  = ($urandom_range(0, 999) < 3) ? 1'b0 : 1'b1;
            r_wr   = ($urandom_range(0, 3) == 0);
            r_addr = 2'($urandom_range(0, 3));
            r_data = (r_addr < 2) ? 16'($urandom_range(0, 72)) : 16'($urandom);
            r_apl  = ($urandom_range(0, 59) == 0);
            r_rd   = 1'b0;
`ifdef SHAPER_CFG_READBACK_EN
            r_rd   = ($urandom_range(0, 3) == 0);
`endif
            applyStimulus(r_rst, r_wr, r_addr, r_data, r_apl, r_rd);
        end

        // Let the monitor consume the final expectation.
        @(negedge clk);
        #1;
        checkOutput("drain", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shaper_cfg_ctrl.md
Name: shaper_cfg_ctrl

Overview:
Runtime configuration and sequencing controller for the trapezoidal shaping filter on the ADC data path.
- Holds shadow and active copies of the filter coefficients k, l, m1, m2; the active copy drives the filter.
- Applies a new coefficient set atomically: the filter is held in reset (flush), then released, and output-valid is gated until the filter pipeline has settled.
- Sits between the slow-control register bus and the filter instance.

Parameters:
CFG_W, 16, width of each coefficient register.
K_DEF, 16, reset/default value of k.
L_DEF, 8, reset/default value of l.
M1_DEF, 2, reset/default value of m1.
M2_DEF, 3, reset/default value of m2.
K_MAX, 64, largest legal k (delay-line depth of the filter).
FLUSH_CYC, 4, cycles the filter reset is held low per apply.
PIPE_LAT, 6, fixed filter pipeline latency added to the settle time.

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-low
cfg_wr  in  1  one-cycle write strobe
cfg_addr  in  2  0=k, 1=l, 2=m1, 3=m2
cfg_wdata  in  CFG_W  write data
cfg_apply  in  1  one-cycle strobe: commit shadow to active
cfg_ack  out  1  pulse, one cycle after cfg_wr
cfg_err  out  1  pulse, one cycle after a rejected apply
busy  out  1  high in FLUSH or SETTLE
filt_rst_n  out  1  drives the filter's active-low reset
k_act, l_act, m1_act, m2_act  out  CFG_W each  active coefficients to the filter
out_valid  out  1  filter output trustworthy (state RUN)

Behaviour:
- Reset (reset=0 at an edge):
  - shadow and active = *_DEF.
  - state=FLUSH, cnt=0, filt_rst_n=0, out_valid=0, busy=1, cfg_ack=0, cfg_err=0.
- States: FLUSH -> SETTLE -> RUN; apply re-enters FLUSH from any state.
- FLUSH:
  - filt_rst_n=0, out_valid=0.
  - cnt counts 0..FLUSH_CYC-1, i.e. exactly FLUSH_CYC cycles; then go to SETTLE with cnt=0.
- SETTLE:
  - filt_rst_n=1, out_valid=0.
  - Lasts exactly k_act+l_act+PIPE_LAT cycles; then go to RUN.
  - cnt width CFG_W+2, so the settle count never wraps.
- RUN: filt_rst_n=1, out_valid=1, busy=0. Stays in RUN until an accepted apply.
- Write:
  - cfg_wr at edge T updates shadow[cfg_addr] at T; cfg_ack=1 during cycle T+1.
  - Writes are accepted in every state and never touch the active set.
- Apply validity check on the effective shadow (see simultaneous write/apply): 1<=k<=K_MAX, l<k, m1 and m2 unrestricted.
  - Invalid: cfg_err=1 for one cycle; state, cnt and active set unchanged.
  - Valid: at the same edge, active<=shadow, state<=FLUSH, cnt<=0, filt_rst_n<=0, out_valid<=0.
- Apply during FLUSH or SETTLE restarts FLUSH with the new set; there is no queueing.
- Simultaneous cfg_wr and cfg_apply in one cycle: the write is merged first, and apply checks and commits the post-write shadow.
- Outputs are registered; active coefficients change only at the edge where FLUSH is entered.
- Reset asserted mid-sequence: immediate return to the reset state above; pending shadow writes are lost.

Optional Feature:
Macro SHAPER_CFG_READBACK_EN.
- Defined:
  - Adds ports cfg_rd (in, 1) and cfg_rdata (out, CFG_W).
  - cfg_rd at edge T drives cfg_rdata during T+1 with the active value at cfg_addr; cfg_ack also pulses.
  - cfg_rd together with cfg_wr: the write wins, and cfg_rdata returns the pre-write active value.
  - cfg_rdata resets to 0.
- Not defined: the ports are absent; no readback logic exists.

Test Plan:
1. Reset low 3 cycles, then high (defaults) -> filt_rst_n low exactly 4 cycles after release, then out_valid rises exactly 16+8+6=30 cycles later; k_act=16, l_act=8.
2. In RUN, write k=32, l=10, then apply -> k_act stays 16 until the apply edge; out_valid low next cycle, filt_rst_n low 4 cycles, out_valid high after 48 further cycles; cfg_ack after each write.
3. Write l=40 (with k=32), then apply -> cfg_err pulses once; state RUN kept, out_valid stays 1, l_act unchanged.
4. Apply, then a second valid apply (k=20, l=4) 10 cycles into SETTLE -> FLUSH restarts for 4 cycles, out_valid rises 30 cycles after that FLUSH ends.
5. Same-cycle cfg_wr(addr 0, data 0) and cfg_apply -> rejected with cfg_err (k=0); the same case with data 12 and l=8 -> accepted with k_act=12.
6. Assert reset during SETTLE -> next cycle all coefficients back to defaults, filt_rst_n=0, out_valid=0, busy=1.
